computie_ad_bus_controller: RTL

Sequences one multiplexed address/data bus cycle at a time on the computie AD pins. It takes single-beat read/write requests from an internal master and runs the phases: address phase (ALE), bus turnaround, data strobe, acknowledge wait with timeout, and recovery. It owns the AD output-enable that feeds the SB_IO tristate pin wrapper, so the wrapper never decides bus direction itself.

---
 rtl/computie_bus_pkg.sv | 39 +++
 rtl/computie_sync2.sv | 34 +++
 rtl/computie_ad_bus_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/computie_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : computie_bus_pkg
// Description : Shared types and default timing for the computie multiplexed
//               address/data bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package computie_bus_pkg;

    // Bus cycle phases, in the order a cycle walks through them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        AHOLD   = 3'd2,
        TURN    = 3'd3,
        DATA    = 3'd4,
        END     = 3'd5,
        RECOVER = 3'd6
    } bus_state_t;

    // Default timing: one cycle per phase, generous ack timeout.
    localparam int c_DEF_AD_WIDTH       = 8;
    localparam int c_DEF_SETUP_CYCLES   = 1;
    localparam int c_DEF_TURN_CYCLES    = 1;
    localparam int c_DEF_TIMEOUT        = 255;
    localparam int c_DEF_RECOVER_CYCLES = 1;

    // Largest of four timing values; sizes the shared phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/computie_sync2.sv
`default_nettype none
// ============================================================================
// Module      : computie_sync2
// Description : Generic two-flop synchronizer for a single asynchronous bit,
//               with a selectable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module computie_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/computie_ad_bus_controller.sv
`default_nettype none
// ============================================================================
// Module      : computie_ad_bus_controller
// Description : Runs one multiplexed address/data bus cycle at a time:
//               address (ALE), hold, turnaround, strobe with ack timeout,
//               end and recovery. Owns the AD output enable that steers the
//               external SB_IO pin wrapper (ad_out/ad_oe/ad_in connect there).
// Revision    : 1.0 - initial release
// ============================================================================
module computie_ad_bus_controller
    import computie_bus_pkg::*;
#(
    parameter int AD_WIDTH       = c_DEF_AD_WIDTH,
    parameter int SETUP_CYCLES   = c_DEF_SETUP_CYCLES,
    parameter int TURN_CYCLES    = c_DEF_TURN_CYCLES,
    parameter int TIMEOUT        = c_DEF_TIMEOUT,
    parameter int RECOVER_CYCLES = c_DEF_RECOVER_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    // Request side
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [AD_WIDTH-1:0] req_addr,
    input  logic [AD_WIDTH-1:0] req_wdata,
    // Response side
    output logic                resp_valid,
    output logic                resp_error,
    output logic [AD_WIDTH-1:0] resp_rdata,
    // Bus pins
    output logic [AD_WIDTH-1:0] ad_out,
    input  logic [AD_WIDTH-1:0] ad_in,
    output logic                ad_oe,
    output logic                ale,
    output logic                rd_n,
    output logic                wr_n,
    input  logic                ack_n
);

    // One counter serves every timed phase; it is cleared on each phase change
    // and the phase exits on its terminal count, so it never wraps.
    localparam int c_CNT_MAX = max4(TIMEOUT, SETUP_CYCLES, TURN_CYCLES, RECOVER_CYCLES);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST   = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TURN_LAST    = c_CNT_W'(TURN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_RECOVER_LAST = c_CNT_W'(RECOVER_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);

    bus_state_t          r_state;
    bus_state_t          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    // Captured request
    logic                r_write;
    logic [AD_WIDTH-1:0] r_addr;
    logic [AD_WIDTH-1:0] r_wdata;
    logic [AD_WIDTH-1:0] w_addr_nxt;

    // Registered pin/response outputs and their next values
    logic [AD_WIDTH-1:0] r_ad_out,       w_ad_out_nxt;
    logic                r_ad_oe,        w_ad_oe_nxt;
    logic                r_ale,          w_ale_nxt;
    logic                r_rd_n,         w_rd_n_nxt;
    logic                r_wr_n,         w_wr_n_nxt;
    logic                r_resp_valid,   w_resp_valid_nxt;
    logic                r_resp_error,   w_resp_error_nxt;
    logic [AD_WIDTH-1:0] r_resp_rdata,   w_resp_rdata_nxt;

    logic                w_ack_s;
    logic                w_accept;

    // Bring the device acknowledge into the clock domain; idles as "ack high".
    computie_sync2 #(
        .RESET_VALUE (1'b1)
    ) u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ack_n),
        .q       (w_ack_s)
    );

    // A new cycle may only start from IDLE once any previous ack has gone away.
    assign req_ready = (r_state == IDLE) && w_ack_s;
    assign w_accept  = req_valid && req_ready;

    // Phase sequencing, response capture, and next-cycle pin values.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_resp_error_nxt = r_resp_error;
        w_resp_rdata_nxt = r_resp_rdata;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ADDR;
                    w_cnt_nxt   = '0;
                end
            end
            ADDR: begin
                if (r_cnt == c_SETUP_LAST) begin
                    w_state_nxt = AHOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            AHOLD: begin
                w_state_nxt = r_write ? DATA : TURN;
                w_cnt_nxt   = '0;
            end
            TURN: begin
                if (r_cnt == c_TURN_LAST) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            DATA: begin
                if (!w_ack_s) begin
                    w_state_nxt      = END;
                    w_cnt_nxt        = '0;
                    w_resp_error_nxt = 1'b0;
                    w_resp_rdata_nxt = r_write ? '0 : ad_in;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_state_nxt      = END;
                    w_cnt_nxt        = '0;
                    w_resp_error_nxt = 1'b1;
                    w_resp_rdata_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            END: begin
                w_state_nxt      = RECOVER;
                w_cnt_nxt        = '0;
                w_resp_error_nxt = 1'b0;
            end
            RECOVER: begin
                if (r_cnt == c_RECOVER_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Address seen by ADDR on its first cycle is the one being captured now.
    assign w_addr_nxt = w_accept ? req_addr : r_addr;

    // Pin values are decoded from the next state so the flops line up with it.
    always_comb begin
        w_ad_oe_nxt      = 1'b0;
        w_ad_out_nxt     = '0;
        w_ale_nxt        = 1'b0;
        w_rd_n_nxt       = 1'b1;
        w_wr_n_nxt       = 1'b1;
        w_resp_valid_nxt = 1'b0;

        case (w_state_nxt)
            ADDR: begin
                w_ad_oe_nxt  = 1'b1;
                w_ad_out_nxt = w_addr_nxt;
                w_ale_nxt    = 1'b1;
            end
            AHOLD: begin
                w_ad_oe_nxt  = 1'b1;
                w_ad_out_nxt = r_addr;
            end
            DATA: begin
                if (r_write) begin
                    w_ad_oe_nxt  = 1'b1;
                    w_ad_out_nxt = r_wdata;
                    w_wr_n_nxt   = 1'b0;
                end else begin
                    w_rd_n_nxt   = 1'b0;
                end
            end
            END: begin
                w_resp_valid_nxt = 1'b1;
                if (r_write) begin
                    w_ad_oe_nxt  = 1'b1;
                    w_ad_out_nxt = r_wdata;
                end
            end
            default: begin
            end
        endcase
    end

    // State, counter, captured request and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ad_out     <= '0;
            r_ad_oe      <= 1'b0;
            r_ale        <= 1'b0;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            r_ad_out     <= w_ad_out_nxt;
            r_ad_oe      <= w_ad_oe_nxt;
            r_ale        <= w_ale_nxt;
            r_rd_n       <= w_rd_n_nxt;
            r_wr_n       <= w_wr_n_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_error <= w_resp_error_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
        end
    end

    assign ad_out     = r_ad_out;
    assign ad_oe      = r_ad_oe;
    assign ale        = r_ale;
    assign rd_n       = r_rd_n;
    assign wr_n       = r_wr_n;
    assign resp_valid = r_resp_valid;
    assign resp_error = r_resp_error;
    assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire
